// File: rtl/multicycle_addsub.sv
// multicycle_addsub: adds or subtracts WIDTH-bit operands CHUNK bits per clock, with the carry held in a register between chunks
module multicycle_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic             c_o, c_msb, last;
  always_comb begin
    a_c          = a_q[k_q*CHUNK +: CHUNK];
    b_c          = b_q[k_q*CHUNK +: CHUNK];
    {c_o, s_c}   = {1'b0, a_c} + {1'b0, b_c} + (CHUNK+1)'(carry_q);
    // carry into the top bit recovered from the top sum bit and its operand bits
    c_msb        = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    last         = k_q == KW'(N-1);
    state_d      = state_q;
    k_d          = k_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = RUN;
        a_d     = A;
        b_d     = B ^ {WIDTH{Sub}};
        carry_d = Cin ^ Sub;
        acc_d   = '0;
        k_d     = '0;
      end
      RUN: begin
        acc_d[k_q*CHUNK +: CHUNK] = s_c;
        carry_d = c_o;
        k_d     = last ? '0 : k_q + KW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = c_o;
          ovf_d   = c_msb ^ c_o;
          zero_d  = acc_d == '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign Busy     = state_q == RUN;
  assign Done     = state_q == DONE;
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
endmodule

// File: tb/tb_multicycle_addsub.sv
// tb_multicycle_addsub: directed and random checks of multicycle_addsub against an arithmetic reference model
module tb_multicycle_addsub;
  localparam int N = 4;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, cout, ovf, zero, busy1, done1, cout1, ovf1, zero1;
  logic [31:0] sum, sum1;
  logic [31:0] prev_sum = '0;
  logic        prev_cout = 1'b0, prev_ovf = 1'b0, prev_zero = 1'b0;
  int          passed = 0, total = 0;

  multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .Busy(busy), .Done(done), .Sum(sum), .Cout(cout), .Overflow(ovf), .Zero(zero));

  multicycle_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (
    .Clk(clk), .Reset(rst), .Start(start1), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .Busy(busy1), .Done(done1), .Sum(sum1), .Cout(cout1), .Overflow(ovf1), .Zero(zero1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // true integer result; overflow when the signed result does not fit in 32 bits
  task automatic model(input logic [31:0] x, y, input logic ci, s,
                       output logic [31:0] r, output logic co, ov, z);
    longint sx, sy, sr;
    logic [32:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      u  = {1'b0, x} + {1'b0, y} + 33'(ci);
      co = u[32];
      sr = sx + sy + longint'(ci);
    end else begin
      u  = {1'b0, x} - {1'b0, y} - 33'(ci);
      co = ~u[32];
      sr = sx - sy - longint'(ci);
    end
    r  = u[31:0];
    ov = sr != longint'($signed(r));
    z  = r == 32'd0;
  endtask

  task automatic run_op(input logic [31:0] x, y, input logic ci, s,
                        input bit hold, disturb, check_idle);
    logic [31:0] er;
    logic eco, eov, ez;
    model(x, y, ci, s, er, eco, eov, ez);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    if (hold) begin
      @(posedge clk); #1;
      chk("start_ignored_in_done", {busy, done}, 2'b00);
    end
    @(posedge clk); #1;
    chk("busy_after_accept", {busy, done}, 2'b10);
    chk("sum_held_in_run", sum, prev_sum);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      start = disturb;
      if (disturb) begin a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); end
      @(posedge clk); #1;
      chk("busy_run", {busy, done}, 2'b10);
      chk("flags_held_in_run", {cout, ovf, zero}, {prev_cout, prev_ovf, prev_zero});
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", {busy, done}, 2'b01);
    chk("sum", sum, er);
    chk("flags", {cout, ovf, zero}, {eco, eov, ez});
    prev_sum = er; prev_cout = eco; prev_ovf = eov; prev_zero = ez;
    if (check_idle) begin
      @(posedge clk); #1;
      chk("idle_after_done", {busy, done}, 2'b00);
      chk("sum_held_idle", sum, er);
    end
  endtask

  task automatic run_op1(input logic [31:0] x, y, input logic ci, s);
    logic [31:0] er;
    logic eco, eov, ez;
    model(x, y, ci, s, er, eco, eov, ez);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; start1 = 1'b1;
    @(posedge clk); #1;
    chk("n1_busy", {busy1, done1}, 2'b10);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("n1_done", {busy1, done1}, 2'b01);
    chk("n1_sum", sum1, er);
    chk("n1_flags", {cout1, ovf1, zero1}, {eco, eov, ez});
    @(posedge clk); #1;
    chk("n1_idle", {busy1, done1}, 2'b00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, sum, cout, ovf, zero}, '0);
    chk("reset_outputs_n1", {busy1, done1, sum1, cout1, ovf1, zero1}, '0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 0, 1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 0, 1);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 0, 1);
    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0, 0, 1);
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, 0, 1);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, 0, 1);
    // abort in the second RUN cycle
    @(negedge clk);
    a = 32'h12345678; b = 32'h0F0F0F0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_reset", {busy, done, sum, cout, ovf, zero}, '0);
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {busy, done}, 2'b00);
    end
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, 0, 1);
    run_op($urandom, $urandom, 1'b0, 1'b0, 0, 1, 1);
    run_op($urandom, $urandom, 1'b1, 1'b1, 0, 1, 1);
    run_op($urandom, $urandom, 1'b0, 1'b0, 0, 0, 0);
    run_op($urandom, $urandom, 1'b1, 1'b1, 1, 0, 1);
    for (int i = 0; i < 24; i++)
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), 0, 0, 1);
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 0, 0, 1);
    run_op(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 0, 0, 1);
    run_op1(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    run_op1(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op1(32'h00000005, 32'h00000007, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op1($urandom, $urandom, 1'($urandom), 1'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
